// File: rtl/quiz_pkg.sv
// Shared types and field widths for the quiz arbiter.
// Holds the round state encoding and the lowest-index priority encoder.
package quiz_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    LOCKED  = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

  localparam int ID_W_MAX = 4;   // enough for 16 channels
  localparam int SEC_W    = 7;   // seconds field, up to 99
  localparam int PRESC_W  = 16;  // tick prescaler
  localparam int DB_CNT_W = 4;   // debounce run-length counter

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [ID_W_MAX-1:0] prio_enc(input logic [15:0] req);
    logic [ID_W_MAX-1:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (req[i]) idx = ID_W_MAX'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/quiz_arbiter_if.sv
// Host/button/display signal bundle for quiz_arbiter.
// foul_mask only exists when FOUL_DETECT_EN is defined.
interface quiz_arbiter_if #(
  parameter int CHANNELS = 8
) ();
  import quiz_pkg::*;

  localparam int ID_W = $clog2(CHANNELS);

  logic                host_start;
  logic                host_clear;
  logic [CHANNELS-1:0] btn;
  logic                winner_valid;
  logic [ID_W-1:0]     winner_id;
  logic [SEC_W-1:0]    sec_left;
  logic                timeout;
  logic                armed;
`ifdef FOUL_DETECT_EN
  logic [CHANNELS-1:0] foul_mask;
`endif

  // master: host + button pins; slave: the arbiter
  modport master (
    output host_start, host_clear, btn,
`ifdef FOUL_DETECT_EN
    input  foul_mask,
`endif
    input  winner_valid, winner_id, sec_left, timeout, armed
  );

  modport slave (
    input  host_start, host_clear, btn,
`ifdef FOUL_DETECT_EN
    output foul_mask,
`endif
    output winner_valid, winner_id, sec_left, timeout, armed
  );

endinterface

// File: rtl/btn_debouncer.sv
// Single-channel button debouncer sampled on the slow tick.
// Level flips after DEBOUNCE_TICKS consecutive differing samples; press marks a 0->1 flip.
module btn_debouncer
  import quiz_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_TICKS - 1);

  logic                raw_meta_q, raw_meta_d;
  logic                raw_sync_q, raw_sync_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                press_q, press_d;

  // raw pin is asynchronous, so it is synchronised before being sampled
  always_comb begin
    raw_meta_d = raw;
    raw_sync_d = raw_meta_q;
    cnt_d      = cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    if (tick) begin
      if (raw_sync_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = ~level_q;
          cnt_d   = '0;
          press_d = ~level_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_meta_q <= 1'b0;
      raw_sync_q <= 1'b0;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      raw_meta_q <= raw_meta_d;
      raw_sync_q <= raw_sync_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/quiz_arbiter.sv
// Quiz round arbiter: slow-clock tick recovery, per-channel debounce, first-press grant, countdown.
// Optional FOUL_DETECT_EN adds foul_mask: presses in IDLE are flagged and excluded from the round.
module quiz_arbiter
  import quiz_pkg::*;
#(
  parameter int CHANNELS       = 8,
  parameter int TICK_HZ        = 100,
  parameter int DEBOUNCE_TICKS = 2,
  parameter int ANSWER_SECS    = 30
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            slow_clk,
  quiz_arbiter_if.slave   bus
);

  localparam int                  ID_W       = $clog2(CHANNELS);
  localparam logic [SEC_W-1:0]    SECS_INIT  = SEC_W'(ANSWER_SECS);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(TICK_HZ - 1);

  logic                slow_meta_q, slow_meta_d;
  logic                slow_sync_q, slow_sync_d;
  logic                slow_prev_q, slow_prev_d;
  logic [1:0]          prime_q, prime_d;
  logic                tick_q, tick_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [SEC_W-1:0]    sec_q, sec_d;
  logic [ID_W-1:0]     win_id_q, win_id_d;
  state_e              state_q, state_d;

  logic [CHANNELS-1:0] db_level;
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] valid_press;
  logic [CHANNELS-1:0] eff_press;

`ifdef FOUL_DETECT_EN
  logic [CHANNELS-1:0] foul_q, foul_d;
`endif

  // Ticks stay blocked until the synchroniser holds real samples,
  // so a slow_clk already high at reset release is not seen as an edge.
  always_comb begin
    slow_meta_d = slow_clk;
    slow_sync_d = slow_meta_q;
    slow_prev_d = slow_sync_q;
    prime_d     = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
    tick_d      = slow_sync_q & ~slow_prev_q & (prime_q == 2'd3);
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_db
    btn_debouncer #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_q),
      .raw   (bus.btn[g]),
      .level (db_level[g]),
      .press (press[g])
    );
  end

  assign valid_press = press & db_level;
`ifdef FOUL_DETECT_EN
  assign eff_press = valid_press & ~foul_q;
`else
  assign eff_press = valid_press;
`endif

  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    presc_d  = presc_q;
    win_id_d = win_id_q;
`ifdef FOUL_DETECT_EN
    foul_d   = foul_q;
`endif
    if (bus.host_clear) begin
      state_d = IDLE;
      sec_d   = '0;
`ifdef FOUL_DETECT_EN
      foul_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
`ifdef FOUL_DETECT_EN
          foul_d = foul_q | valid_press;
`endif
          if (bus.host_start) begin
            state_d = ARMED;
            sec_d   = SECS_INIT;
            presc_d = '0;
          end
        end
        ARMED: begin
          // a press beats the countdown even on the cycle sec_left would hit 0
          if (|eff_press) begin
            state_d  = LOCKED;
            win_id_d = ID_W'(prio_enc(16'(eff_press)));
          end else if (tick_q) begin
            if (presc_q == PRESC_LAST) begin
              presc_d = '0;
              sec_d   = sec_q - 1'b1;
              if (sec_q == SEC_W'(1)) state_d = TIMEOUT;
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        LOCKED, TIMEOUT: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slow_meta_q <= 1'b0;
      slow_sync_q <= 1'b0;
      slow_prev_q <= 1'b0;
      prime_q     <= 2'd0;
      tick_q      <= 1'b0;
      presc_q     <= '0;
      sec_q       <= '0;
      win_id_q    <= '0;
      state_q     <= IDLE;
`ifdef FOUL_DETECT_EN
      foul_q      <= '0;
`endif
    end else begin
      slow_meta_q <= slow_meta_d;
      slow_sync_q <= slow_sync_d;
      slow_prev_q <= slow_prev_d;
      prime_q     <= prime_d;
      tick_q      <= tick_d;
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      win_id_q    <= win_id_d;
      state_q     <= state_d;
`ifdef FOUL_DETECT_EN
      foul_q      <= foul_d;
`endif
    end
  end

  assign bus.winner_valid = (state_q == LOCKED);
  assign bus.timeout      = (state_q == TIMEOUT);
  assign bus.armed        = (state_q == ARMED);
  assign bus.winner_id    = win_id_q;
  assign bus.sec_left     = sec_q;
`ifdef FOUL_DETECT_EN
  assign bus.foul_mask    = foul_q;
`endif

endmodule
